complete_sub: RTL

Sequential floating-point magnitude subtractor for the team's 32-bit format: bits 31:24 are an unsigned exponent and bits 23:0 an unsigned mantissa, with no sign bit and no hidden bit. It is the counterpart of the combinational adder. It returns |A−B| plus a sign flag. After alignment and subtraction, it normalizes the result one bit per cycle behind a start/done handshake. It sits beside the adder in the FPU datapath; together they cover addition and subtraction.

---
 rtl/complete_sub_pkg.sv | 26 ++
 rtl/complete_sub_if.sv | 17 +
 rtl/sub_align.sv | 23 ++
 rtl/complete_sub.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/complete_sub_pkg.sv
// Shared widths, state encoding and guard configuration for the magnitude subtractor.
// COMPLETE_SUB_GUARD_EN adds one guard bit to the aligned datapath.
package complete_sub_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = 24;
  localparam int unsigned DATA_W = EXP_W + MAN_W;

`ifdef COMPLETE_SUB_GUARD_EN
  localparam int unsigned GUARD_W = 1;
`else
  localparam int unsigned GUARD_W = 0;
`endif

  // Internal subtract/normalize width: mantissa plus optional guard LSB
  localparam int unsigned DW = MAN_W + GUARD_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_SUB   = 3'd2,
    S_NORM  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/complete_sub_if.sv
// Start/done request bus of the magnitude subtractor.
interface complete_sub_if;
  import complete_sub_pkg::*;

  logic              start;
  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opB;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] res;
  logic              neg;
  logic              zero;

  modport master (output start, opA, opB, input busy, done, res, neg, zero);
  modport slave  (input start, opA, opB, output busy, done, res, neg, zero);

endinterface

// File: rtl/sub_align.sv
// Combinational right shifter aligning the smaller operand's mantissa;
// also returns the last bit shifted out (guard). Shifts of MAN_W or more give 0.
module sub_align
  import complete_sub_pkg::*;
(
  input  logic [MAN_W-1:0] mant_i,
  input  logic [EXP_W-1:0] shamt_i,
  output logic [MAN_W-1:0] aligned_c,
  output logic             guard_c
);

  logic [MAN_W:0] ext;

  always_comb begin
    ext = '0;
    if (shamt_i < EXP_W'(MAN_W)) begin
      ext = {mant_i, 1'b0} >> shamt_i;
    end
    aligned_c = ext[MAN_W:1];
    guard_c   = ext[0];
  end

endmodule

// File: rtl/complete_sub.sv
// Sequential magnitude subtractor: align, subtract, then normalize one bit per cycle.
// Build with COMPLETE_SUB_GUARD_EN to keep one guard bit through subtract/normalize.
module complete_sub
  import complete_sub_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  complete_sub_if.slave bus
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [DW-1:0]       mant_l_q, mant_l_d, als_q, als_d, diff_q, diff_d;
  logic [EXP_W-1:0]    el_q, el_d;
  logic                l_is_b_q, l_is_b_d, neg_w_q, neg_w_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                neg_q, neg_d, zero_q, zero_d;
  logic [DATA_W-1:0]   res_q, res_d;

  logic [EXP_W-1:0]    exp_a_c, exp_b_c, shamt_c;
  logic [MAN_W-1:0]    man_a_c, man_b_c, man_l_c, man_s_c, aligned_c;
  logic                guard_c, b_larger_c, norm_stop_c, diff_zero_c;

  // Operand split and L/S selection; equal exponents keep A as L
  assign exp_a_c    = a_q[DATA_W-1 -: EXP_W];
  assign exp_b_c    = b_q[DATA_W-1 -: EXP_W];
  assign man_a_c    = a_q[MAN_W-1:0];
  assign man_b_c    = b_q[MAN_W-1:0];
  assign b_larger_c = exp_b_c > exp_a_c;
  assign shamt_c    = b_larger_c ? (exp_b_c - exp_a_c) : (exp_a_c - exp_b_c);
  assign man_l_c    = b_larger_c ? man_b_c : man_a_c;
  assign man_s_c    = b_larger_c ? man_a_c : man_b_c;

  sub_align u_align (
    .mant_i    (man_s_c),
    .shamt_i   (shamt_c),
    .aligned_c (aligned_c),
    .guard_c   (guard_c)
  );

  assign diff_zero_c = (diff_q == '0);
  assign norm_stop_c = diff_q[DW-1] | diff_zero_c | (el_q == '0);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mant_l_d = mant_l_q;
    als_d    = als_q;
    diff_d   = diff_q;
    el_d     = el_q;
    l_is_b_d = l_is_b_q;
    neg_w_d  = neg_w_q;
    done_d   = 1'b0;
    neg_d    = neg_q;
    zero_d   = zero_q;
    res_d    = res_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.opA;
          b_d     = bus.opB;
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        mant_l_d = DW'(man_l_c) << GUARD_W;
        als_d    = (DW'(aligned_c) << GUARD_W) | DW'(guard_c & 1'(GUARD_W));
        el_d     = b_larger_c ? exp_b_c : exp_a_c;
        l_is_b_d = b_larger_c;
        state_d  = S_SUB;
      end
      S_SUB: begin
        // A tie leaves neg at 0 regardless of which operand was L
        if (mant_l_q >= als_q) begin
          diff_d  = mant_l_q - als_q;
          neg_w_d = l_is_b_q && (mant_l_q != als_q);
        end else begin
          diff_d  = als_q - mant_l_q;
          neg_w_d = !l_is_b_q;
        end
        state_d = S_NORM;
      end
      S_NORM: begin
        if (norm_stop_c) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          res_d   = diff_zero_c ? '0 : {el_q, diff_q[DW-1 -: MAN_W]};
          neg_d   = neg_w_q;
          zero_d  = diff_zero_c;
        end else begin
          diff_d = diff_q << 1;
          el_d   = el_q - EXP_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mant_l_q <= '0;
      als_q    <= '0;
      diff_q   <= '0;
      el_q     <= '0;
      l_is_b_q <= 1'b0;
      neg_w_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mant_l_q <= mant_l_d;
      als_q    <= als_d;
      diff_q   <= diff_d;
      el_q     <= el_d;
      l_is_b_q <= l_is_b_d;
      neg_w_q  <= neg_w_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      res_q    <= res_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.res  = res_q;
  assign bus.neg  = neg_q;
  assign bus.zero = zero_q;

endmodule
